// File: rtl/game_pkg.sv
// Shared types and constants for the PS/2 player key decoder.
package game_pkg;

  typedef enum logic [1:0] {
    KS_IDLE    = 2'd0,
    KS_BRK     = 2'd1,
    KS_EXT     = 2'd2,
    KS_EXT_BRK = 2'd3
  } kbd_state_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BAT   = 8'hAA;

  localparam logic [7:0] DEF_TOM_LEFT    = 8'h6B;
  localparam logic [7:0] DEF_TOM_RIGHT   = 8'h74;
  localparam logic [7:0] DEF_TOM_JUMP    = 8'h75;
  localparam logic [7:0] DEF_JERRY_LEFT  = 8'h1C;
  localparam logic [7:0] DEF_JERRY_RIGHT = 8'h23;
  localparam logic [7:0] DEF_JERRY_JUMP  = 8'h1D;

  typedef struct packed {
    logic tom_left;
    logic tom_right;
    logic tom_jump;
    logic jerry_left;
    logic jerry_right;
    logic jerry_jump;
  } keys_t;

endpackage

// File: rtl/ps2_seq_timeout.sv
// Saturating inter-byte timer; expire_o is high in the cycle whose increment reaches TIMEOUT_CYCLES.
module ps2_seq_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 650_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] CNT_MAX  = W'(TIMEOUT_CYCLES);
  localparam logic [W-1:0] CNT_LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                         cnt_d = '0;
    else if (en_i && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  // A clear in the same cycle wins over expiry.
  assign expire_o = en_i && !clr_i && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/player_key_decoder.sv
// PS/2 set-2 scan codes -> held key levels for Tom (E0 arrows) and Jerry (plain WAD).
// Define JUMP_ONESHOT_EN to make the jump outputs one-cycle pulses per press.
module player_key_decoder
  import game_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES   = 650_000,
  parameter logic [7:0]  TOM_LEFT_CODE    = DEF_TOM_LEFT,
  parameter logic [7:0]  TOM_RIGHT_CODE   = DEF_TOM_RIGHT,
  parameter logic [7:0]  TOM_JUMP_CODE    = DEF_TOM_JUMP,
  parameter logic [7:0]  JERRY_LEFT_CODE  = DEF_JERRY_LEFT,
  parameter logic [7:0]  JERRY_RIGHT_CODE = DEF_JERRY_RIGHT,
  parameter logic [7:0]  JERRY_JUMP_CODE  = DEF_JERRY_JUMP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_code,
  input  logic       key_valid,
  output logic       tom_left,
  output logic       tom_right,
  output logic       tom_jump,
  output logic       jerry_left,
  output logic       jerry_right,
  output logic       jerry_jump,
  output logic       seq_err
);
  kbd_state_t state_q, state_d;
  keys_t      keys_q, keys_d;
  logic       seq_err_q, seq_err_d;
  logic       expire, done, ext, mk;
`ifdef JUMP_ONESHOT_EN
  logic       tom_held_q, tom_held_d, jerry_held_q, jerry_held_d;
`endif

  ps2_seq_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (key_valid),
    .en_i     (state_q != KS_IDLE),
    .expire_o (expire)
  );

  // done marks the final byte of a sequence; ext/mk qualify it.
  always_comb begin
    state_d   = state_q;
    seq_err_d = 1'b0;
    done      = 1'b0;
    ext       = 1'b0;
    mk        = 1'b0;
    if (key_valid) begin
      state_d = KS_IDLE;
      case (state_q)
        KS_IDLE: begin
          if (key_code == PS2_BREAK)    state_d = KS_BRK;
          else if (key_code == PS2_EXT) state_d = KS_EXT;
          else begin done = 1'b1; mk = 1'b1; end
        end
        KS_BRK: done = 1'b1;
        KS_EXT: begin
          if (key_code == PS2_BREAK)    state_d = KS_EXT_BRK;
          else if (key_code == PS2_EXT) state_d = KS_EXT;
          else begin done = 1'b1; ext = 1'b1; mk = 1'b1; end
        end
        default: begin done = 1'b1; ext = 1'b1; end
      endcase
    end else if (expire) begin
      state_d   = KS_IDLE;
      seq_err_d = 1'b1;
    end
  end

  always_comb begin
    keys_d = keys_q;
`ifdef JUMP_ONESHOT_EN
    keys_d.tom_jump   = 1'b0;
    keys_d.jerry_jump = 1'b0;
    tom_held_d        = tom_held_q;
    jerry_held_d      = jerry_held_q;
`endif
    if (done && !ext && mk && key_code == PS2_BAT) begin
      keys_d = '0;
`ifdef JUMP_ONESHOT_EN
      tom_held_d   = 1'b0;
      jerry_held_d = 1'b0;
`endif
    end else if (done && ext) begin
      if (key_code == TOM_LEFT_CODE)  keys_d.tom_left  = mk;
      if (key_code == TOM_RIGHT_CODE) keys_d.tom_right = mk;
      if (key_code == TOM_JUMP_CODE) begin
`ifdef JUMP_ONESHOT_EN
        keys_d.tom_jump = mk & ~tom_held_q;
        tom_held_d      = mk;
`else
        keys_d.tom_jump = mk;
`endif
      end
    end else if (done) begin
      if (key_code == JERRY_LEFT_CODE)  keys_d.jerry_left  = mk;
      if (key_code == JERRY_RIGHT_CODE) keys_d.jerry_right = mk;
      if (key_code == JERRY_JUMP_CODE) begin
`ifdef JUMP_ONESHOT_EN
        keys_d.jerry_jump = mk & ~jerry_held_q;
        jerry_held_d      = mk;
`else
        keys_d.jerry_jump = mk;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= KS_IDLE;
      keys_q    <= '0;
      seq_err_q <= 1'b0;
`ifdef JUMP_ONESHOT_EN
      tom_held_q   <= 1'b0;
      jerry_held_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      keys_q    <= keys_d;
      seq_err_q <= seq_err_d;
`ifdef JUMP_ONESHOT_EN
      tom_held_q   <= tom_held_d;
      jerry_held_q <= jerry_held_d;
`endif
    end
  end

  assign tom_left    = keys_q.tom_left;
  assign tom_right   = keys_q.tom_right;
  assign tom_jump    = keys_q.tom_jump;
  assign jerry_left  = keys_q.jerry_left;
  assign jerry_right = keys_q.jerry_right;
  assign jerry_jump  = keys_q.jerry_jump;
  assign seq_err     = seq_err_q;
endmodule

// File: tb/tb_player_key_decoder.sv
// Directed bench for player_key_decoder; outs = {tl,tr,tj,jl,jr,jj}.
module tb_player_key_decoder;
  localparam int unsigned TMO = 20;
`ifdef JUMP_ONESHOT_EN
  localparam logic JJ_HELD = 1'b0;
`else
  localparam logic JJ_HELD = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key_code = 8'h00;
  logic       key_valid = 1'b0;
  logic       tom_left, tom_right, tom_jump, jerry_left, jerry_right, jerry_jump, seq_err;
  logic [5:0] outs;
  int         n_vec = 0;
  int         n_err = 0;

  assign outs = {tom_left, tom_right, tom_jump, jerry_left, jerry_right, jerry_jump};

  always #5 clk = ~clk;

  player_key_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .tom_left    (tom_left),
    .tom_right   (tom_right),
    .tom_jump    (tom_jump),
    .jerry_left  (jerry_left),
    .jerry_right (jerry_right),
    .jerry_jump  (jerry_jump),
    .seq_err     (seq_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe one byte; returns at the falling edge after the sampling edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    key_code  = b;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  initial begin
    int pulses;
    int first;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_outs", 32'(outs), 32'h0);
    chk("reset_err", 32'(seq_err), 32'h0);

    // Jerry left make / break
    send(8'h1C);            chk("a_make", 32'(outs), 32'b000100);
    send(8'hF0);            chk("a_brk_pfx", 32'(outs), 32'b000100);
    send(8'h1C);            chk("a_break", 32'(outs), 32'b000000);

    // Tom right; plain break/make of 74 must not touch Tom
    send(8'hE0); send(8'h74);               chk("right_make", 32'(outs), 32'b010000);
    send(8'hF0); send(8'h74);               chk("plain_brk_74", 32'(outs), 32'b010000);
    send(8'hE0); send(8'hF0); send(8'h74);  chk("right_break", 32'(outs), 32'b000000);
    send(8'h74);                            chk("plain_74", 32'(outs), 32'b000000);
    send(8'h6B);                            chk("plain_6b", 32'(outs), 32'b000000);

    // Opposing keys both held
    send(8'hE0); send(8'h6B); send(8'hE0); send(8'h74);
    chk("left_right", 32'(outs), 32'b110000);
    send(8'hE0); send(8'hF0); send(8'h6B);  chk("rel_left", 32'(outs), 32'b010000);
    send(8'hE0); send(8'hF0); send(8'h74);  chk("rel_right", 32'(outs), 32'b000000);

    // Timeout abort with D held
    send(8'h23);            chk("d_make", 32'(outs), 32'b000010);
    send(8'hE0);
    pulses = 0; first = 0;
    for (int i = 1; i <= TMO + 10; i++) begin
      @(negedge clk);
      if (seq_err === 1'b1) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    chk("tmo_pulses", 32'(pulses), 32'd1);
    chk("tmo_cycle", 32'(first), 32'(TMO));
    chk("tmo_outs", 32'(outs), 32'b000010);
    send(8'h1D);            chk("post_tmo_w", 32'(outs), 32'b000011);

    // Byte arriving in the expiry cycle wins
    send(8'hE0);
    pulses = 0;
    for (int i = 1; i <= TMO - 2; i++) begin
      @(negedge clk);
      if (seq_err === 1'b1) pulses++;
    end
    send(8'h74);
    for (int i = 0; i < 5; i++) begin
      if (seq_err === 1'b1) pulses++;
      @(negedge clk);
    end
    chk("race_no_err", 32'(pulses), 32'd0);
    chk("race_make", 32'(outs), 32'({5'b01001, JJ_HELD}));
    send(8'hE0); send(8'hF0); send(8'h74);  chk("race_rel", 32'(outs), 32'({5'b00001, JJ_HELD}));
    send(8'hF0); send(8'h23);               chk("d_break", 32'(outs), 32'({5'b00000, JJ_HELD}));
    send(8'hF0); send(8'h1D);               chk("w_break", 32'(outs), 32'b000000);

    // Typematic repeat of W
    send(8'h1D);            chk("w_rep1", 32'(outs), 32'b000001);
    @(negedge clk);         chk("w_rep1_next", 32'(outs), 32'({5'b0, JJ_HELD}));
    send(8'h1D);            chk("w_rep2", 32'(outs), 32'({5'b0, JJ_HELD}));
    send(8'h1D);            chk("w_rep3", 32'(outs), 32'({5'b0, JJ_HELD}));
    send(8'hF0); send(8'h1D);               chk("w_rel", 32'(outs), 32'b000000);
    send(8'h1D);            chk("w_again", 32'(outs), 32'b000001);
    send(8'h1D);            chk("w_again_rep", 32'(outs), 32'({5'b0, JJ_HELD}));
    send(8'hF0); send(8'h1D);               chk("w_rel2", 32'(outs), 32'b000000);

    // BAT clears everything
    send(8'h1C); send(8'h23); send(8'hE0); send(8'h75);
    chk("hold_all", 32'(outs), 32'b001110);
    send(8'hAA);            chk("bat_clear", 32'(outs), 32'b000000);

    // Reset mid-sequence
    send(8'h1C);            chk("pre_rst", 32'(outs), 32'b000100);
    send(8'hE0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_outs", 32'(outs), 32'b000000);
    chk("rst_err", 32'(seq_err), 32'h0);
    send(8'hF0); send(8'h1C);               chk("rst_brk", 32'(outs), 32'b000000);
    send(8'h1D);            chk("rst_idle", 32'(outs), 32'b000001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
